// File: rtl/rv32_writeback_if.sv
// rv32_writeback_if: groups the write-back stage's execute, load-issue,
// memory-response, register-file, scoreboard and error signals.
//   master : the producer side (execute, load issue, memory, decode queries)
//   slave  : the write-back stage itself
// Parameter XLEN sets the datapath width.
interface rv32_writeback_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_data;

  logic            ld_issue;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;

  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wdata;

  logic [4:0]      sb_ra1;
  logic [4:0]      sb_ra2;
  logic            sb_busy1;
  logic            sb_busy2;

  logic            err_spurious;
  logic            err_overflow;

  modport master (
    output ex_valid, ex_rd, ex_data,
    output ld_issue, ld_rd, ld_funct3, ld_addr_lo,
    output mem_rvalid, mem_rdata,
    output sb_ra1, sb_ra2,
    input  ex_ready, ld_ready,
    input  rf_we, rf_wa, rf_wdata,
    input  sb_busy1, sb_busy2,
    input  err_spurious, err_overflow
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data,
    input  ld_issue, ld_rd, ld_funct3, ld_addr_lo,
    input  mem_rvalid, mem_rdata,
    input  sb_ra1, sb_ra2,
    output ex_ready, ld_ready,
    output rf_we, rf_wa, rf_wdata,
    output sb_busy1, sb_busy2,
    output err_spurious, err_overflow
  );
endinterface

// File: rtl/rv32_writeback.sv
// rv32_writeback: write-back stage driving the register file write port.
// Merges execute results with load responses (load responses win the port),
// sign/zero-extends load data by funct3 and address lane, and keeps an
// in-order pending-load queue that also serves as a decode hazard scoreboard.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; discards all pending loads
//   wb     rv32_writeback_if.slave bundle:
//          ex_valid/ex_ready/ex_rd/ex_data        execute result handshake
//          ld_issue/ld_ready/ld_rd/ld_funct3/ld_addr_lo  load issue into queue
//          mem_rvalid/mem_rdata                   load response (always accepted)
//          rf_we/rf_wa/rf_wdata                   registered register file write
//          sb_ra1/sb_ra2 -> sb_busy1/sb_busy2     combinational scoreboard query
//          err_spurious/err_overflow              sticky error flags
// Parameters: XLEN datapath width, LD_DEPTH queue depth (power of 2, >= 2).
module rv32_writeback #(
  parameter int XLEN     = 32,
  parameter int LD_DEPTH = 2
) (
  input logic        clk,
  input logic        reset,
  rv32_writeback_if.slave wb
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;

  // Pending-load queue storage; q_vld marks occupied slots so the
  // scoreboard can search without decoding pointer distance.
  logic [4:0]          q_rd  [LD_DEPTH];
  logic [2:0]          q_f3  [LD_DEPTH];
  logic [1:0]          q_lo  [LD_DEPTH];
  logic [LD_DEPTH-1:0] q_vld;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic q_empty;
  logic q_full;
  logic pop;
  logic push;
  logic drop;
  logic spurious;

  logic ex_match;
  logic ra1_match;
  logic ra2_match;
  logic ex_hit;
  logic ex_ready_i;
  logic ex_accept;

  logic            sel;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            wr_now;

  logic            rf_we_q;
  logic [4:0]      rf_wa_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            err_spurious_q;
  logic            err_overflow_q;

  function automatic logic [XLEN-1:0] load_extract(
    input logic [2:0]      f3,
    input logic [1:0]      lo,
    input logic [XLEN-1:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[16 +: 16] : w[0 +: 16];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign q_empty  = (count == '0);
  assign q_full   = (count == CW'(LD_DEPTH));
  assign pop      = wb.mem_rvalid && !q_empty;
  assign spurious = wb.mem_rvalid && q_empty;
  // A full queue still takes a new load when the head leaves the same cycle.
  assign push     = wb.ld_issue && (!q_full || pop);
  assign drop     = wb.ld_issue && q_full && !pop;

  always_comb begin
    ex_match  = 1'b0;
    ra1_match = 1'b0;
    ra2_match = 1'b0;
    for (int unsigned i = 0; i < LD_DEPTH; i++) begin
      if (q_vld[i]) begin
        if (q_rd[i] == wb.ex_rd)  ex_match  = 1'b1;
        if (q_rd[i] == wb.sb_ra1) ra1_match = 1'b1;
        if (q_rd[i] == wb.sb_ra2) ra2_match = 1'b1;
      end
    end
  end

  // The WAW stall looks at the whole queue, including a head that is
  // popping this cycle, so an execute result never overtakes its load.
  assign ex_hit     = (wb.ex_rd != '0) && ex_match;
  assign ex_ready_i = !wb.mem_rvalid && !ex_hit;
  assign ex_accept  = wb.ex_valid && ex_ready_i;

  always_comb begin
    sel      = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (pop) begin
      sel      = 1'b1;
      sel_rd   = q_rd[rd_ptr];
      sel_data = load_extract(q_f3[rd_ptr], q_lo[rd_ptr], wb.mem_rdata);
    end else if (ex_accept) begin
      sel      = 1'b1;
      sel_rd   = wb.ex_rd;
      sel_data = wb.ex_data;
    end
  end

  assign wr_now = sel && (sel_rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_vld  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Clear before set: when full with push and pop, both pointers hit
      // the same slot and the incoming load must own it.
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (push) begin
        q_vld[wr_ptr] <= 1'b1;
        q_rd[wr_ptr]  <= wb.ld_rd;
        q_f3[wr_ptr]  <= wb.ld_funct3;
        q_lo[wr_ptr]  <= wb.ld_addr_lo;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q        <= 1'b0;
      rf_wa_q        <= '0;
      rf_wdata_q     <= '0;
      err_spurious_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      rf_we_q <= wr_now;
      if (wr_now) begin
        rf_wa_q    <= sel_rd;
        rf_wdata_q <= sel_data;
      end
      if (spurious) err_spurious_q <= 1'b1;
      if (drop)     err_overflow_q <= 1'b1;
    end
  end

  assign wb.ex_ready     = ex_ready_i;
  assign wb.ld_ready     = !q_full;
  assign wb.rf_we        = rf_we_q;
  assign wb.rf_wa        = rf_wa_q;
  assign wb.rf_wdata     = rf_wdata_q;
  assign wb.err_spurious = err_spurious_q;
  assign wb.err_overflow = err_overflow_q;

  // The register file has no write-to-read bypass, so the register being
  // written this cycle is still reported busy.
  assign wb.sb_busy1 = (wb.sb_ra1 != '0) &&
                       (ra1_match || (rf_we_q && rf_wa_q == wb.sb_ra1));
  assign wb.sb_busy2 = (wb.sb_ra2 != '0) &&
                       (ra2_match || (rf_we_q && rf_wa_q == wb.sb_ra2));

endmodule

// File: tb/tb_rv32_writeback.sv
module tb_rv32_writeback;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32_writeback_if #(.XLEN(32)) wb ();

  rv32_writeback #(.XLEN(32), .LD_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb.slave)
  );

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } ld_t;

  ld_t         pq[$];
  int          total = 0;
  int          bad   = 0;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wdata;
  logic        m_spur;
  logic        m_ovf;

  // Load extraction from the RV32I rules using plain integer arithmetic.
  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] lo,
                                      input logic [31:0] w);
    longint v;
    int unsigned bsh;
    int unsigned hsh;
    bsh = 8 * int'(lo);
    hsh = 16 * int'(lo[1]);
    case (f3)
      3'd0: begin v = longint'((w >> bsh) & 32'hFF);   if (v >= 128)   v = v - 256;   end
      3'd4: v = longint'((w >> bsh) & 32'hFF);
      3'd1: begin v = longint'((w >> hsh) & 32'hFFFF); if (v >= 32768) v = v - 65536; end
      3'd5: v = longint'((w >> hsh) & 32'hFFFF);
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic bit in_q(input logic [4:0] rd);
    foreach (pq[i]) if (pq[i].rd == rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit busy(input logic [4:0] ra);
    return (ra != 0) && (in_q(ra) || (m_we && m_wa == ra));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb.ex_valid   = 1'b0;
    wb.ex_rd      = '0;
    wb.ex_data    = '0;
    wb.ld_issue   = 1'b0;
    wb.ld_rd      = '0;
    wb.ld_funct3  = '0;
    wb.ld_addr_lo = '0;
    wb.mem_rvalid = 1'b0;
    wb.mem_rdata  = '0;
    wb.sb_ra1     = '0;
    wb.sb_ra2     = '0;
  endtask

  task automatic model_edge();
    bit          pop;
    bit          full;
    bit          acc;
    bit          sel;
    logic [4:0]  rd;
    logic [31:0] d;
    ld_t         h;
    ld_t         n;
    sel = 1'b0;
    rd  = '0;
    d   = '0;
    if (reset) begin
      pq.delete();
      m_we = 1'b0; m_wa = '0; m_wdata = '0; m_spur = 1'b0; m_ovf = 1'b0;
    end else begin
      pop  = wb.mem_rvalid && pq.size() > 0;
      full = pq.size() >= 2;
      acc  = wb.ex_valid && !wb.mem_rvalid && !(wb.ex_rd != 0 && in_q(wb.ex_rd));
      if (pop) begin
        h = pq.pop_front();
        sel = 1'b1; rd = h.rd; d = ext(h.f3, h.lo, wb.mem_rdata);
      end else if (acc) begin
        sel = 1'b1; rd = wb.ex_rd; d = wb.ex_data;
      end
      if (wb.mem_rvalid && !pop) m_spur = 1'b1;
      if (wb.ld_issue) begin
        if (!full || pop) begin
          n.rd = wb.ld_rd; n.f3 = wb.ld_funct3; n.lo = wb.ld_addr_lo;
          pq.push_back(n);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_we = sel && rd != 0;
      if (m_we) begin m_wa = rd; m_wdata = d; end
    end
  endtask

  // One clock: check combinational outputs with the current inputs, advance
  // the model at the edge, then check the registered outputs.
  task automatic step();
    #1;
    check("ex_ready", 32'(wb.ex_ready),
          32'(!wb.mem_rvalid && !(wb.ex_rd != 0 && in_q(wb.ex_rd))));
    check("ld_ready", 32'(wb.ld_ready), 32'(pq.size() < 2));
    check("sb_busy1", 32'(wb.sb_busy1), 32'(busy(wb.sb_ra1)));
    check("sb_busy2", 32'(wb.sb_busy2), 32'(busy(wb.sb_ra2)));
    @(posedge clk);
    model_edge();
    #1;
    check("rf_we",        32'(wb.rf_we),        32'(m_we));
    check("rf_wa",        32'(wb.rf_wa),        32'(m_wa));
    check("rf_wdata",     wb.rf_wdata,          m_wdata);
    check("err_spurious", 32'(wb.err_spurious), 32'(m_spur));
    check("err_overflow", 32'(wb.err_overflow), 32'(m_ovf));
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    wb.ld_issue = 1'b1; wb.ld_rd = rd; wb.ld_funct3 = f3; wb.ld_addr_lo = lo;
  endtask

  task automatic respond(input logic [31:0] data);
    wb.mem_rvalid = 1'b1; wb.mem_rdata = data;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    pq.delete();
    m_we = 1'b0; m_wa = '0; m_wdata = '0; m_spur = 1'b0; m_ovf = 1'b0;
    step(); step();
    reset = 1'b0;
    check("reset_rf_we", 32'(wb.rf_we), 32'd0);
    check("reset_ld_ready", 32'(wb.ld_ready), 32'd1);

    // ALU write
    idle(); wb.ex_valid = 1'b1; wb.ex_rd = 5'd5; wb.ex_data = 32'h1234;
    #1 check("t1_ex_ready", 32'(wb.ex_ready), 32'd1);
    step(); idle();
    check("t1_we", 32'(wb.rf_we), 32'd1);
    check("t1_wa", 32'(wb.rf_wa), 32'd5);
    check("t1_wdata", wb.rf_wdata, 32'h1234);

    // Load extension cases
    issue(5'd3, 3'b000, 2'd2); step(); idle();
    respond(32'h0080_0000); step(); idle();
    check("t2_lb", wb.rf_wdata, 32'hFFFF_FF80);
    issue(5'd3, 3'b100, 2'd2); step(); idle();
    respond(32'h0080_0000); step(); idle();
    check("t2_lbu", wb.rf_wdata, 32'h0000_0080);
    issue(5'd3, 3'b101, 2'd2); step(); idle();
    respond(32'hBEEF_0000); step(); idle();
    check("t2_lhu", wb.rf_wdata, 32'h0000_BEEF);

    // WAW stall behind a load, then simultaneous response and ALU result
    issue(5'd7, 3'b010, 2'd0); step(); idle();
    wb.ex_valid = 1'b1; wb.ex_rd = 5'd7; wb.ex_data = 32'hAAAA; wb.sb_ra1 = 5'd7;
    #1 check("t3_stall", 32'(wb.ex_ready), 32'd0);
    check("t3_busy", 32'(wb.sb_busy1), 32'd1);
    step(); step();
    respond(32'h0000_0055);
    #1 check("t4_ex_blocked", 32'(wb.ex_ready), 32'd0);
    step();
    check("t3_load_first", wb.rf_wdata, 32'h0000_0055);
    wb.mem_rvalid = 1'b0;
    step();
    check("t3_alu_next", wb.rf_wdata, 32'h0000_AAAA);
    idle(); wb.sb_ra1 = 5'd7; step(); step();

    // Queue full, push with pop, overflow drop, spurious
    issue(5'd1, 3'b010, 2'd0); step();
    issue(5'd2, 3'b010, 2'd0); step(); idle();
    #1 check("t5_full", 32'(wb.ld_ready), 32'd0);
    issue(5'd4, 3'b010, 2'd0); respond(32'h1111_1111); step(); idle();
    issue(5'd6, 3'b010, 2'd0); step(); idle();
    check("t5_overflow", 32'(wb.err_overflow), 32'd1);
    respond(32'h2222_2222); step(); step(); step(); idle();
    check("t5_spurious", 32'(wb.err_spurious), 32'd1);

    // Reset with loads pending, then rd=0 load
    reset = 1'b1; step(); reset = 1'b0;
    issue(5'd9, 3'b010, 2'd0); step();
    issue(5'd10, 3'b010, 2'd0); step(); idle();
    reset = 1'b1; step(); reset = 1'b0;
    wb.sb_ra1 = 5'd9; wb.sb_ra2 = 5'd10;
    #1 check("t6_busy_clear", 32'({wb.sb_busy1, wb.sb_busy2}), 32'd0);
    step(); idle();
    issue(5'd0, 3'b010, 2'd0); step(); idle();
    respond(32'hDEAD_BEEF); step(); idle();
    check("t6_rd0_nowrite", 32'(wb.rf_we), 32'd0);
    step();

    // Randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      reset         = ($urandom_range(0, 99) == 0);
      wb.ex_valid   = $urandom_range(0, 1);
      wb.ex_rd      = 5'($urandom_range(0, 7));
      wb.ex_data    = $urandom;
      wb.ld_issue   = ($urandom_range(0, 2) == 0);
      wb.ld_rd      = 5'($urandom_range(0, 7));
      wb.ld_funct3  = 3'($urandom_range(0, 7));
      wb.ld_addr_lo = 2'($urandom_range(0, 3));
      wb.mem_rvalid = ($urandom_range(0, 2) == 0);
      wb.mem_rdata  = $urandom;
      wb.sb_ra1     = 5'($urandom_range(0, 7));
      wb.sb_ra2     = 5'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
